ciclo_lectura_rtc: RTL and testbench

Bus-cycle generator directly downstream of the read-sequence controller. It consumes `activa` and the 8-bit register address that the controller drives. It then runs one multiplexed address/data read cycle on the RTC parallel bus: an address-write phase, a separation gap, and a data-read phase. It returns the captured byte plus a one-cycle `fin` pulse, which the controller uses to leave its read state.

---
 rtl/ciclo_rtc_pkg.sv | 39 +++
 rtl/contador_fase.sv | 34 +++
 rtl/ciclo_lectura_rtc.sv | 163 ++++++++++++++++
 tb/tb_ciclo_lectura_rtc.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ciclo_rtc_pkg.sv
// Shared definitions for the RTC read-cycle generator: state encoding,
// bus idle pattern and default phase timings.
package ciclo_rtc_pkg;

    typedef enum logic [2:0] {
        REPOSO      = 3'd0,
        ESC_DIR     = 3'd1,
        SEP         = 3'd2,
        LEE_DATO    = 3'd3,
        TERMINA     = 3'd4,
        ESPERA_BAJA = 3'd5
    } estado_t;

    localparam int T_PULSO_DEF = 4;
    localparam int T_SEP_DEF   = 2;

    // {cs_n, rd_n, wr_n} all deasserted
    localparam logic [2:0] STROBES_REPOSO = 3'b111;
    localparam logic       OE_REPOSO      = 1'b0;

    typedef struct packed {
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       ad;
        logic       oe;
        logic [7:0] dout;
    } bus_t;

    localparam bus_t BUS_REPOSO = '{
        cs_n: STROBES_REPOSO[2],
        rd_n: STROBES_REPOSO[1],
        wr_n: STROBES_REPOSO[0],
        ad:   1'b1,
        oe:   OE_REPOSO,
        dout: 8'h00
    };

endpackage

// File: rtl/contador_fase.sv
// 8-bit loadable down-counter timing each bus phase; ultimo_o flags the
// final cycle of the phase (count equal to one).
module contador_fase (
    input  logic       clk,
    input  logic       reset,
    input  logic       carga_i,
    input  logic [7:0] valor_i,
    input  logic       decr_i,
    output logic       ultimo_o
);

    logic [7:0] cuenta_q;
    logic [7:0] cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (carga_i) begin
            cuenta_d = valor_i;
        end else if (decr_i && (cuenta_q != 8'd0)) begin
            cuenta_d = cuenta_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta_q <= 8'd0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign ultimo_o = (cuenta_q == 8'd1);

endmodule

// File: rtl/ciclo_lectura_rtc.sv
// Runs one multiplexed address/data read cycle on the RTC parallel bus
// per request: address write, separation gap, data read, completion pulse.
module ciclo_lectura_rtc
    import ciclo_rtc_pkg::*;
#(
    parameter int T_PULSO = T_PULSO_DEF,
    parameter int T_SEP   = T_SEP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activa,
    input  logic [7:0] dir,
    input  logic [7:0] bus_ad_in,
    output logic [7:0] bus_ad_out,
    output logic       bus_ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad,
    output logic [7:0] dato,
    output logic       dato_valido,
    output logic       fin
);

    localparam logic [7:0] T_PULSO_C = 8'(T_PULSO);
    localparam logic [7:0] T_SEP_C   = 8'(T_SEP);

    estado_t    estado_q, estado_d;
    logic [7:0] dir_q, dir_d;
    bus_t       bus_q, bus_d;
    logic [7:0] dato_q, dato_d;
    logic       fin_q, fin_d;

    logic       carga;
    logic [7:0] valor;
    logic       decr;
    logic       ultimo;

    contador_fase u_contador (
        .clk      (clk),
        .reset    (reset),
        .carga_i  (carga),
        .valor_i  (valor),
        .decr_i   (decr),
        .ultimo_o (ultimo)
    );

    // Outputs are computed from the next state so every strobe is registered
    // and changes on the edge that enters its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= REPOSO;
            dir_q    <= 8'h00;
            bus_q    <= BUS_REPOSO;
            dato_q   <= 8'h00;
            fin_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            dir_q    <= dir_d;
            bus_q    <= bus_d;
            dato_q   <= dato_d;
            fin_q    <= fin_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        carga    = 1'b0;
        valor    = T_PULSO_C;
        decr     = 1'b0;
        case (estado_q)
            REPOSO: begin
                if (activa) begin
                    estado_d = ESC_DIR;
                    carga    = 1'b1;
                    valor    = T_PULSO_C;
                end
            end
            ESC_DIR, SEP, LEE_DATO: begin
                // Losing the request mid-cycle aborts without a completion pulse
                if (!activa) begin
                    estado_d = REPOSO;
                    carga    = 1'b1;
                    valor    = 8'd0;
                end else if (ultimo) begin
                    carga = 1'b1;
                    case (estado_q)
                        ESC_DIR: begin
                            estado_d = SEP;
                            valor    = T_SEP_C;
                        end
                        SEP: begin
                            estado_d = LEE_DATO;
                            valor    = T_PULSO_C;
                        end
                        default: begin
                            estado_d = TERMINA;
                            valor    = 8'd0;
                        end
                    endcase
                end else begin
                    decr = 1'b1;
                end
            end
            TERMINA: begin
                estado_d = ESPERA_BAJA;
            end
            ESPERA_BAJA: begin
                if (!activa) begin
                    estado_d = REPOSO;
                end
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_comb begin
        bus_d  = BUS_REPOSO;
        dir_d  = dir_q;
        dato_d = dato_q;
        fin_d  = 1'b0;
        if ((estado_q == REPOSO) && activa) begin
            dir_d = dir;
        end
        case (estado_d)
            ESC_DIR: begin
                bus_d.cs_n = 1'b0;
                bus_d.wr_n = 1'b0;
                bus_d.ad   = 1'b0;
                bus_d.oe   = 1'b1;
                bus_d.dout = dir_d;
            end
            LEE_DATO: begin
                bus_d.cs_n = 1'b0;
                bus_d.rd_n = 1'b0;
                bus_d.ad   = 1'b1;
                bus_d.oe   = 1'b0;
            end
            TERMINA: begin
                fin_d = 1'b1;
            end
            default: begin
            end
        endcase
        // Capture on the last rd_n-low sample, i.e. the edge leaving the read phase
        if ((estado_q == LEE_DATO) && (estado_d == TERMINA)) begin
            dato_d = bus_ad_in;
        end
    end

    assign cs_n        = bus_q.cs_n;
    assign rd_n        = bus_q.rd_n;
    assign wr_n        = bus_q.wr_n;
    assign ad          = bus_q.ad;
    assign bus_ad_oe   = bus_q.oe;
    assign bus_ad_out  = bus_q.dout;
    assign dato        = dato_q;
    assign dato_valido = fin_q;
    assign fin         = fin_q;

endmodule

// File: tb/tb_ciclo_lectura_rtc.sv
// Self-checking bench for ciclo_lectura_rtc: default-timing instance plus a
// T_PULSO=1/T_SEP=1 instance, with a byte scoreboard per instance.
module tb_ciclo_lectura_rtc;

    logic       clk = 1'b0;
    logic       reset;

    logic       activa, activa2;
    logic [7:0] dir, dir2;
    logic [7:0] bus_ad_in, bus_ad_in2;

    logic [7:0] bus_ad_out, bus_ad_out2;
    logic       bus_ad_oe, bus_ad_oe2;
    logic       cs_n, cs_n2, rd_n, rd_n2, wr_n, wr_n2, ad, ad2;
    logic [7:0] dato, dato2;
    logic       dato_valido, dato_valido2, fin, fin2;

    logic [4:0] sal, sal2;

    int         checks   = 0;
    int         failures = 0;

    logic [7:0] cola[$];
    logic [7:0] cola2[$];
    logic [7:0] sb_esp, sb_esp2;

    localparam logic [4:0] P_REPOSO = 5'b11110;

    always #5 clk = ~clk;

    ciclo_lectura_rtc dut (
        .clk         (clk),
        .reset       (reset),
        .activa      (activa),
        .dir         (dir),
        .bus_ad_in   (bus_ad_in),
        .bus_ad_out  (bus_ad_out),
        .bus_ad_oe   (bus_ad_oe),
        .cs_n        (cs_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .ad          (ad),
        .dato        (dato),
        .dato_valido (dato_valido),
        .fin         (fin)
    );

    ciclo_lectura_rtc #(.T_PULSO(1), .T_SEP(1)) dut_rapido (
        .clk         (clk),
        .reset       (reset),
        .activa      (activa2),
        .dir         (dir2),
        .bus_ad_in   (bus_ad_in2),
        .bus_ad_out  (bus_ad_out2),
        .bus_ad_oe   (bus_ad_oe2),
        .cs_n        (cs_n2),
        .rd_n        (rd_n2),
        .wr_n        (wr_n2),
        .ad          (ad2),
        .dato        (dato2),
        .dato_valido (dato_valido2),
        .fin         (fin2)
    );

    assign sal  = {cs_n, rd_n, wr_n, ad, bus_ad_oe};
    assign sal2 = {cs_n2, rd_n2, wr_n2, ad2, bus_ad_oe2};

    // Expected {cs_n, rd_n, wr_n, ad, oe} in the cycle after edge E0+i
    function automatic logic [4:0] patron(int i, int tp, int ts);
        if (i < tp)               return 5'b01001;
        else if (i < tp + ts)     return 5'b11110;
        else if (i < 2 * tp + ts) return 5'b00110;
        else                      return 5'b11110;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every dato_valido pops one expected byte; also watches
    // fin/dato_valido agreement and bus contention.
    always @(negedge clk) begin
        checks++;
        if (fin !== dato_valido || fin2 !== dato_valido2) begin
            failures++;
            $display("[TB] FAIL fin_vs_valido got=%b/%b,%b/%b expected equal pairs", fin, dato_valido, fin2, dato_valido2);
        end
        checks++;
        if ((bus_ad_oe === 1'b1 && rd_n === 1'b0) || (bus_ad_oe2 === 1'b1 && rd_n2 === 1'b0)) begin
            failures++;
            $display("[TB] FAIL contienda_bus got oe=%b rd_n=%b oe2=%b rd_n2=%b expected no oe with rd_n low",
                     bus_ad_oe, rd_n, bus_ad_oe2, rd_n2);
        end
        if (dato_valido === 1'b1) begin
            checks++;
            if (cola.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb_inesperado got dato=%h expected no dato_valido", dato);
            end else begin
                sb_esp = cola.pop_front();
                if (dato !== sb_esp) begin
                    failures++;
                    $display("[TB] FAIL sb_dato got=%h expected=%h", dato, sb_esp);
                end
            end
        end
        if (dato_valido2 === 1'b1) begin
            checks++;
            if (cola2.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb2_inesperado got dato2=%h expected no dato_valido", dato2);
            end else begin
                sb_esp2 = cola2.pop_front();
                if (dato2 !== sb_esp2) begin
                    failures++;
                    $display("[TB] FAIL sb2_dato got=%h expected=%h", dato2, sb_esp2);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        activa = 1'b0; activa2 = 1'b0;
        dir = 8'h00; dir2 = 8'h00;
        bus_ad_in = 8'h00; bus_ad_in2 = 8'h00;
        tick();
        tick();
        checks++;
        if (sal !== P_REPOSO || bus_ad_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_bus got=%b/%h expected=%b/00", sal, bus_ad_out, P_REPOSO);
        end
        checks++;
        if (dato !== 8'h00 || dato_valido !== 1'b0 || fin !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_dato got=%h/%b/%b expected=00/0/0", dato, dato_valido, fin);
        end
        checks++;
        if (sal2 !== P_REPOSO || bus_ad_out2 !== 8'h00 || dato2 !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_rapido got=%b/%h/%h expected=%b/00/00", sal2, bus_ad_out2, dato2, P_REPOSO);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sal !== P_REPOSO || fin !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reposo_sin_activa got=%b/%b expected=%b/0", sal, fin, P_REPOSO);
            end
        end
    endtask

    task automatic test_nominal();
        dir = 8'h25; bus_ad_in = 8'h59; activa = 1'b1;
        cola.push_back(8'h59);
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (sal !== patron(i, 4, 2)) begin
                failures++;
                $display("[TB] FAIL nominal_bus ciclo=%0d got=%b expected=%b", i, sal, patron(i, 4, 2));
            end
            checks++;
            if (bus_ad_out !== ((i < 4) ? 8'h25 : 8'h00)) begin
                failures++;
                $display("[TB] FAIL nominal_dir ciclo=%0d got=%h expected=%h", i, bus_ad_out, (i < 4) ? 8'h25 : 8'h00);
            end
            checks++;
            if (fin !== (i == 10)) begin
                failures++;
                $display("[TB] FAIL nominal_fin ciclo=%0d got=%b expected=%b", i, fin, i == 10);
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (sal !== P_REPOSO || fin !== 1'b0) begin
                failures++;
                $display("[TB] FAIL espera_baja ciclo=%0d got=%b/%b expected=%b/0", i, sal, fin, P_REPOSO);
            end
        end
        checks++;
        if (cola.size() != 0) begin
            failures++;
            $display("[TB] FAIL nominal_pendientes got=%0d expected=0", cola.size());
        end
        checks++;
        if (dato !== 8'h59) begin
            failures++;
            $display("[TB] FAIL nominal_dato got=%h expected=59", dato);
        end
        activa = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        dir = 8'h10; bus_ad_in = 8'hEE; activa = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (sal !== patron(i, 4, 2)) begin
                failures++;
                $display("[TB] FAIL aborta_bus ciclo=%0d got=%b expected=%b", i, sal, patron(i, 4, 2));
            end
        end
        activa = 1'b0;
        tick();
        checks++;
        if (cs_n !== 1'b1 || rd_n !== 1'b1 || sal !== P_REPOSO) begin
            failures++;
            $display("[TB] FAIL aborta_inmediato got=%b expected=%b", sal, P_REPOSO);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (fin !== 1'b0 || sal !== P_REPOSO) begin
                failures++;
                $display("[TB] FAIL aborta_reposo ciclo=%0d got=%b/%b expected=%b/0", i, sal, fin, P_REPOSO);
            end
        end
        checks++;
        if (dato !== 8'h59) begin
            failures++;
            $display("[TB] FAIL aborta_dato got=%h expected=59", dato);
        end
    endtask

    task automatic test_async_reset();
        dir = 8'h66; bus_ad_in = 8'h12; activa = 1'b1;
        tick();
        tick();
        checks++;
        if (sal !== 5'b01001) begin
            failures++;
            $display("[TB] FAIL reset_previo got=%b expected=01001", sal);
        end
        #2;
        reset = 1'b1;
        activa = 1'b0;
        #1;
        checks++;
        if (cs_n !== 1'b1 || wr_n !== 1'b1 || bus_ad_oe !== 1'b0 || bus_ad_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_asincrono got cs_n=%b wr_n=%b oe=%b out=%h expected 1/1/0/00",
                     cs_n, wr_n, bus_ad_oe, bus_ad_out);
        end
        #3;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sal !== P_REPOSO || fin !== 1'b0) begin
                failures++;
                $display("[TB] FAIL tras_reset ciclo=%0d got=%b/%b expected=%b/0", i, sal, fin, P_REPOSO);
            end
        end
        checks++;
        if (dato !== 8'h00) begin
            failures++;
            $display("[TB] FAIL tras_reset_dato got=%h expected=00", dato);
        end
    endtask

    task automatic test_back_to_back();
        dir = 8'h33; bus_ad_in = 8'h5C; activa = 1'b1;
        cola.push_back(8'h5C);
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (fin !== (i == 10)) begin
                failures++;
                $display("[TB] FAIL b2b_fin1 ciclo=%0d got=%b expected=%b", i, fin, i == 10);
            end
        end
        activa = 1'b0;
        tick();
        dir = 8'h41; bus_ad_in = 8'hA3; activa = 1'b1;
        cola.push_back(8'hA3);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) dir = 8'h7F;
            checks++;
            if (sal !== patron(i, 4, 2)) begin
                failures++;
                $display("[TB] FAIL b2b_bus ciclo=%0d got=%b expected=%b", i, sal, patron(i, 4, 2));
            end
            checks++;
            if (bus_ad_out !== ((i < 4) ? 8'h41 : 8'h00)) begin
                failures++;
                $display("[TB] FAIL b2b_dir ciclo=%0d got=%h expected=%h", i, bus_ad_out, (i < 4) ? 8'h41 : 8'h00);
            end
            checks++;
            if (fin !== (i == 10)) begin
                failures++;
                $display("[TB] FAIL b2b_fin2 ciclo=%0d got=%b expected=%b", i, fin, i == 10);
            end
        end
        checks++;
        if (cola.size() != 0 || dato !== 8'hA3) begin
            failures++;
            $display("[TB] FAIL b2b_final got pend=%0d dato=%h expected pend=0 dato=a3", cola.size(), dato);
        end
        activa = 1'b0;
        tick();
    endtask

    task automatic test_tiempos_minimos();
        dir2 = 8'h9C; bus_ad_in2 = 8'h3D; activa2 = 1'b1;
        cola2.push_back(8'h3D);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (sal2 !== patron(i, 1, 1)) begin
                failures++;
                $display("[TB] FAIL minimo_bus ciclo=%0d got=%b expected=%b", i, sal2, patron(i, 1, 1));
            end
            checks++;
            if (bus_ad_out2 !== ((i < 1) ? 8'h9C : 8'h00)) begin
                failures++;
                $display("[TB] FAIL minimo_dir ciclo=%0d got=%h expected=%h", i, bus_ad_out2, (i < 1) ? 8'h9C : 8'h00);
            end
            checks++;
            if (fin2 !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL minimo_fin ciclo=%0d got=%b expected=%b", i, fin2, i == 3);
            end
        end
        activa2 = 1'b0;
        tick();
        checks++;
        if (cola2.size() != 0 || dato2 !== 8'h3D) begin
            failures++;
            $display("[TB] FAIL minimo_final got pend=%0d dato=%h expected pend=0 dato=3d", cola2.size(), dato2);
        end
    endtask

    initial begin
        reset = 1'b1;
        activa = 1'b0; activa2 = 1'b0;
        test_reset();
        test_nominal();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_tiempos_minimos();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
